// File: rtl/edge_pkg.sv
// Shared constants and types for the edge binarize/pack stage.
// Default frame geometry, pack width and control FSM states.
package edge_pkg;

  localparam int DEF_IMG_WIDTH  = 16;
  localparam int DEF_IMG_HEIGHT = 8;
  localparam int PACK_W         = 8;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

endpackage

// File: rtl/edge_bit_packer.sv
// Packs a stream of 1-bit values LSB-first into bytes.
// Ports: clk, rst (sync, active-high), bit_valid/bit_in/idx in,
// byte_valid (1-cycle pulse) and byte_out (held) out.
module edge_bit_packer
  import edge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic [2:0]        idx,
  output logic              byte_valid,
  output logic [PACK_W-1:0] byte_out
);

  logic [PACK_W-1:0] acc;
  logic [PACK_W-1:0] merged;

  // Bits above idx are always zero: acc clears after each byte.
  always_comb begin
    merged      = acc;
    merged[idx] = bit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      byte_valid <= 1'b0;
      byte_out   <= '0;
    end else begin
      byte_valid <= 1'b0;
      if (bit_valid) begin
        if (idx == 3'd7) begin
          byte_out   <= merged;
          byte_valid <= 1'b1;
          acc        <= '0;
        end else begin
          acc <= merged;
        end
      end
    end
  end

endmodule

// File: rtl/edge_binarize_packer.sv
// Thresholds a gradient stream into a packed 1-bit edge map.
// Ports: clk, rst, thresh_in, pixel_in_valid/pixel_in in; byte_out_valid,
// byte_out, row_end, frame_done, edge_count out (all registered).
module edge_binarize_packer
  import edge_pkg::*;
#(
  parameter  int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter  int IMG_HEIGHT = DEF_IMG_HEIGHT,
  localparam int CNT_W      = $clog2(IMG_WIDTH*IMG_HEIGHT+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        thresh_in,
  input  logic              pixel_in_valid,
  input  logic [7:0]        pixel_in,
  output logic              byte_out_valid,
  output logic [PACK_W-1:0] byte_out,
  output logic              row_end,
  output logic              frame_done,
  output logic [CNT_W-1:0]  edge_count
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W =
    (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST =
    COL_W'(IMG_WIDTH-1);
  localparam logic [ROW_W-1:0] ROW_LAST =
    ROW_W'(IMG_HEIGHT-1);

  state_t            state_q;
  state_t            state_d;
  logic [7:0]        thr_q;
  logic [7:0]        thr;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [CNT_W-1:0]  run_cnt;
  logic              edge_bit;
  logic              at_col_last;
  logic              at_last;

  // The first pixel of a frame sees the threshold being latched.
  assign thr = (state_q == ST_IDLE) ? thresh_in : thr_q;

  assign edge_bit    = (pixel_in >= thr);
  assign at_col_last = (col == COL_LAST);
  assign at_last     = at_col_last && (row == ROW_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pixel_in_valid) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (pixel_in_valid && at_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q      <= '0;
      col        <= '0;
      row        <= '0;
      run_cnt    <= '0;
      edge_count <= '0;
      row_end    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      row_end    <= 1'b0;
      frame_done <= 1'b0;
      if (pixel_in_valid) begin
        if (state_q == ST_IDLE) thr_q <= thresh_in;
        row_end    <= at_col_last;
        frame_done <= at_last;
        if (at_col_last) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (at_last) begin
          edge_count <= run_cnt + CNT_W'(edge_bit);
          run_cnt    <= '0;
        end else if (edge_bit) begin
          run_cnt <= run_cnt + 1'b1;
        end
      end
    end
  end

  edge_bit_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (pixel_in_valid),
    .bit_in     (edge_bit),
    .idx        (col[2:0]),
    .byte_valid (byte_out_valid),
    .byte_out   (byte_out)
  );

endmodule

// File: tb/tb_edge_binarize_packer.sv
// Randomized self-checking bench for edge_binarize_packer.
// Reference expectations are derived per frame from pixel arrays.
module tb_edge_binarize_packer;
  import edge_pkg::*;

  localparam int W    = 16;
  localparam int H    = 8;
  localparam int NPIX = W*H;
  localparam int CW   = $clog2(NPIX+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    thresh_in = '0;
  logic          pixel_in_valid = 1'b0;
  logic [7:0]    pixel_in = '0;
  logic          byte_out_valid;
  logic [7:0]    byte_out;
  logic          row_end;
  logic          frame_done;
  logic [CW-1:0] edge_count;

  edge_binarize_packer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .thresh_in      (thresh_in),
    .pixel_in_valid (pixel_in_valid),
    .pixel_in       (pixel_in),
    .byte_out_valid (byte_out_valid),
    .byte_out       (byte_out),
    .row_end        (row_end),
    .frame_done     (frame_done),
    .edge_count     (edge_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  b;
    logic        re;
    logic        fd;
    int          cnt;
    int unsigned due;
  } exp_t;

  exp_t       expq[$];
  exp_t       mon_e;
  logic [7:0] pix [NPIX];
  int         checks = 0;
  int         failures = 0;
  int         frames_seen = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (byte_out_valid) begin
      if (expq.size() == 0) begin
        check("spurious_byte", 1, 0);
      end else begin
        mon_e = expq.pop_front();
        check("byte", byte_out, mon_e.b);
        check("row_end", row_end, mon_e.re);
        check("frame_done", frame_done, mon_e.fd);
        check("latency", cyc, mon_e.due);
        if (mon_e.fd) begin
          check("edge_count", edge_count, mon_e.cnt);
          frames_seen++;
        end
      end
    end else if (row_end || frame_done) begin
      check("stray_pulse", {row_end, frame_done}, 0);
    end
  end

  // Drives pixels 0..n-1 of pix[]; thresh_in switches to thr1
  // from pixel chg_at on, but the frame must keep using thr0.
  task automatic run_frame(input int n,
                           input logic [7:0] thr0,
                           input logic [7:0] thr1,
                           input int chg_at,
                           input int gap_max);
    int         cnt;
    int         g;
    logic       eb;
    logic [7:0] acc;
    exp_t       e;
    cnt = 0;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
        pixel_in_valid = 1'b0;
        pixel_in       = 8'($urandom);
        if (i > 0) thresh_in = 8'($urandom);
        @(posedge clk); #1;
      end
      pixel_in_valid = 1'b1;
      pixel_in       = pix[i];
      thresh_in      = (i < chg_at) ? thr0 : thr1;
      eb             = (pix[i] >= thr0);
      cnt           += int'(eb);
      acc[i%8]       = eb;
      if (i % 8 == 7) begin
        e.b   = acc;
        e.re  = ((i % W) == W-1);
        e.fd  = (i == NPIX-1);
        e.cnt = cnt;
        e.due = cyc + 1;
        expq.push_back(e);
      end
      @(posedge clk); #1;
      pixel_in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    pixel_in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_pix();
    for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  logic [7:0] rthr;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", byte_out_valid, 0);
    check("rst_byte", byte_out, 0);
    check("rst_row_end", row_end, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_edge_count", edge_count, 0);

    for (int i = 0; i < NPIX; i++) pix[i] = 8'd200;
    run_frame(NPIX, 8'd128, 8'd128, NPIX, 0);
    idle(3);

    for (int i = 0; i < NPIX; i++)
      pix[i] = (i % 2 == 1) ? 8'd255 : 8'd0;
    run_frame(NPIX, 8'd255, 8'd255, NPIX, 0);
    idle(2);

    for (int i = 0; i < NPIX; i++)
      pix[i] = (i % 2 == 1) ? 8'd127 : 8'd128;
    run_frame(NPIX, 8'd128, 8'd128, NPIX, 0);
    idle(2);

    for (int i = 0; i < NPIX; i++) pix[i] = 8'd150;
    run_frame(NPIX, 8'd100, 8'd250, 6, 0);
    idle(2);
    run_frame(NPIX, 8'd250, 8'd250, NPIX, 0);
    idle(2);

    for (int f = 0; f < 2; f++) begin
      rand_pix();
      rthr = 8'($urandom);
      run_frame(NPIX, rthr, 8'($urandom),
                int'($urandom_range(NPIX-1, 1)), 5);
      idle(1);
    end

    rand_pix();
    run_frame(37, 8'd90, 8'd90, 37, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_edge_count", edge_count, 0);
    check("midrst_valid", byte_out_valid, 0);
    idle(4);
    check("midrst_pending", expq.size(), 0);
    rand_pix();
    run_frame(NPIX, 8'($urandom), 8'd0, NPIX, 0);
    idle(2);

    rand_pix();
    rthr = 8'($urandom);
    run_frame(NPIX, rthr, rthr, NPIX, 0);
    rand_pix();
    rthr = 8'($urandom);
    run_frame(NPIX, rthr, rthr, NPIX, 0);
    idle(5);

    check("drain", expq.size(), 0);
    check("frames_seen", frames_seen, 10);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_binarize_packer.md
# edge_binarize_packer

Downstream stage for the Sobel accelerator's output stream. It takes the 8-bit gradient-magnitude stream (`pixel_out_valid` / `pixel_out` of `sobel_accelerator`) and compares each pixel to a per-frame threshold. The resulting 1-bit edge map is packed LSB-first into bytes. It also tracks row/column position and reports the frame's edge-pixel count when the frame ends. There is no backpressure: the upstream stage cannot stall, so every valid input must be consumed in the cycle it arrives.

## Interface

Parameters:
- `IMG_WIDTH`, default 16: pixels per row; must be a multiple of 8 and at least 8.
- `IMG_HEIGHT`, default 8: rows per frame; at least 1.
- `CNT_W`, localparam = $clog2(IMG_WIDTH*IMG_HEIGHT+1): width of the edge count.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `thresh_in`  in  8  edge threshold; sampled once per frame.
- `pixel_in_valid`  in  1  input pixel valid; a pixel is accepted on every rising edge where this is high.
- `pixel_in`  in  8  gradient magnitude.
- `byte_out_valid`  out  1  one-cycle pulse; `byte_out` holds 8 packed edge bits.
- `byte_out`  out  8  packed edge bits; bit k = k-th pixel of the group.
- `row_end`  out  1  pulses with the last byte of each row.
- `frame_done`  out  1  pulses with the last byte of each frame.
- `edge_count`  out  CNT_W  number of edge pixels in the last completed frame.

## Operation

- **Control FSM.** Two states, IDLE and ACTIVE. Reset enters IDLE.
- **IDLE → ACTIVE.** Taken on the first accepted pixel.
  - `thresh_in` is latched into `thr_q` on that same edge.
  - That first pixel is compared against the newly latched value, i.e. `thresh_in` directly.
- **ACTIVE → IDLE.** Taken on the edge that accepts pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- **Mid-frame threshold changes.** Changes to `thresh_in` while ACTIVE are ignored.
- **Edge bit.** edge = (pixel_in >= thr), an unsigned 8-bit compare.
  - thr = 0 makes every pixel an edge.
  - thr = 255 makes only pixels equal to 255 edges.
- **Position counters.** `col` runs 0..IMG_WIDTH-1 and `row` runs 0..IMG_HEIGHT-1.
  - Both advance only on accepted pixels.
  - `col` wraps to 0 and increments `row`; `row` wraps to 0 at frame end.
  - Gaps in `pixel_in_valid` (any length) freeze all state.
- **Packing.** `col[2:0]` is the bit index into an 8-bit shift/accumulate register.
  - When `col[2:0]==7`, the completed byte is registered to `byte_out`.
  - The accumulator clears in that same cycle.
- **Running count.** `run_cnt` increments on every accepted edge pixel.
  - At frame end, `edge_count` ← run_cnt plus the last pixel's edge bit.
  - `run_cnt` clears to 0 in the same cycle.
  - `edge_count` holds its value until the next frame end.
- **Reset mid-frame.**
  - All counters, the accumulator and the FSM clear.
  - `edge_count` also clears.
  - The partial byte is discarded and not emitted.
  - The next accepted pixel is treated as (0,0).
- **Stale/tail pixels.** None are possible: every frame is exactly IMG_WIDTH*IMG_HEIGHT accepted pixels.

## Timing

- All outputs are registered.
- **Reset values.** `byte_out_valid`=0, `byte_out`=0, `row_end`=0, `frame_done`=0, `edge_count`=0.
- **Byte latency.** Exactly 1 cycle: the 8th pixel of a group is accepted on edge N, and `byte_out_valid` is high in the cycle after edge N, for one cycle.
- **Pulse alignment.**
  - `row_end` is coincident with the `byte_out_valid` for col=IMG_WIDTH-1.
  - `frame_done` is coincident with the `byte_out_valid` for the final pixel; `row_end` is also high then.
  - `edge_count` shows the new value starting in the `frame_done` cycle.
- **Throughput.** One pixel per clock sustained. Back-to-back bytes produce `byte_out_valid` high once per 8 accepted pixels.
- **Back-to-back frames.** The first pixel of frame F+1 may arrive on the edge immediately after the last pixel of frame F; its threshold is sampled on that edge.
- **Output hold.** `byte_out` holds its last value when `byte_out_valid` is low; consumers qualify it with valid.

## Structure

- **Package `edge_pkg`:**
  - default IMG_WIDTH/IMG_HEIGHT;
  - `PACK_W` = 8;
  - the FSM state enum {ST_IDLE, ST_ACTIVE}.
- **Sub-module `edge_bit_packer`:**
  - accumulates 1-bit inputs with `bit_valid` and a 3-bit index;
  - emits a registered byte plus valid;
  - the top level keeps the counters, FSM, threshold and count.

## Test plan

- **Solid frames.** Reset, thresh=128, one frame of 128 pixels all 200 → 16 bytes of 8'hFF, `row_end` on bytes 2,4,…,16, `frame_done` with byte 16, `edge_count`=128.
- **Ordering and boundary.** Pattern 0,255 repeated with thresh=255 → every byte = 8'hAA (LSB-first ordering check); `edge_count`=64. Pixel 127 vs thresh 128 → bit 0; pixel 128 → bit 1.
- **Threshold latch.** Change `thresh_in` from 100 to 250 after pixel 5 of a frame of all-150 pixels → all bytes 8'hFF and `edge_count`=128. The next frame, with thresh now 250 → all bytes 8'h00 and `edge_count`=0.
- **Valid gaps.** Random 0–5 cycle gaps in `pixel_in_valid` → byte sequence and count identical to the gapless run; `byte_out_valid` appears exactly 1 cycle after each 8th accepted pixel.
- **Reset mid-frame.** Assert `rst` after 37 pixels → no byte emitted for the partial group and `edge_count`=0. A full frame after reset then produces exactly 16 bytes and a correct `frame_done`.
- **Back-to-back frames.** Two frames with no idle cycle between them → 32 bytes, two `frame_done` pulses 16 bytes apart, and `edge_count` updated at each.
